// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a TX FIFO, STATUS reports
// full/empty/busy/overflow/count, and a serializer drains the FIFO onto tx.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BCNT_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BCNT_ONE    = BW'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_bcnt;
  logic [2:0]      r_bidx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_sel_tx;
  logic            w_sel_st;
  logic            w_push_req;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_ovf_clr;
  logic [3:0]      w_cnt_sat;
  logic [31:0]     w_status;

  assign hit        = (address[31:3] == BASE_ADDR[31:3]);
  assign w_sel_tx   = hit && !address[2];
  assign w_sel_st   = hit && address[2];
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == {CW{1'b0}});
  // The serializer pops when idle, or back-to-back at the final stop-bit cycle.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                                   ((r_state == S_STOP) && (r_bcnt == {BW{1'b0}})));
  assign w_push_req = we && w_sel_tx;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push;
  assign w_ovf_clr  = we && w_sel_st && wdata[3];
  assign w_status   = {24'd0, w_cnt_sat, r_ovf, (r_state != S_IDLE), w_empty, w_full};
  assign tx         = r_tx;

  always_comb begin
    w_cnt_sat = 4'd0;
    if (32'(r_count) > 32'd15) w_cnt_sat = 4'hF;
    else                       w_cnt_sat = 4'(r_count);
  end

  always_comb begin
    rdata = 32'd0;
    if (w_sel_st) rdata = w_status;
    else          rdata = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_bcnt  <= {BW{1'b0}};
      r_bidx  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_bcnt  <= BCNT_RELOAD;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (r_bcnt == {BW{1'b0}}) begin
            r_state <= S_DATA;
            r_bidx  <= 3'd0;
            r_bcnt  <= BCNT_RELOAD;
            r_tx    <= r_shift[0];
          end else begin
            r_bcnt <= r_bcnt - BCNT_ONE;
          end
        end
        S_DATA: begin
          if (r_bcnt == {BW{1'b0}}) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bcnt  <= BCNT_RELOAD;
            if (r_bidx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bidx <= r_bidx + 3'd1;
              r_tx   <= r_shift[1];
            end
          end else begin
            r_bcnt <= r_bcnt - BCNT_ONE;
          end
        end
        S_STOP: begin
          if (r_bcnt == {BW{1'b0}}) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_bcnt  <= BCNT_RELOAD;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt - BCNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register decode table plus serial-frame scoreboard and
// hand-written multi-cycle sequences (frame timing, back-to-back, overflow, reset abort).
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rst_epoch = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  mmio_uart_tx #(.BASE_ADDR(32'h8000_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .address(address), .wdata(wdata), .we(we),
    .hit(hit), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    bus_write(A_TX, {24'd0, b});
    exp_q.push_back(b);
  endtask

  task automatic read_status(output logic [31:0] v);
    @(negedge clk);
    address = A_ST; we = 1'b0;
    #1 v = rdata;
  endtask

  // Serial monitor: samples mid-bit, pops the scoreboard; frames cut by reset are dropped.
  initial begin
    logic [7:0] bits;
    logic       stop_bit;
    int         ep;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        ep = rst_epoch;
        start_q.push_back(cyc);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          bits[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        if (ep == rst_epoch) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL frame_unexpected: got 0x%0h expected no frame", bits);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, bits}, {24'd0, e});
            check("frame_stop", {31'd0, stop_bit}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] st;
    int          bad_idx;
    int          busy_bad;
    int          waited;
    logic        exp_bit;
    logic [7:0]  byte55;

    vecs[0] = '{32'h8000_0004, 1'b0, 32'd0,  1'b1, 32'h02};
    vecs[1] = '{32'h8000_0000, 1'b0, 32'd0,  1'b1, 32'h00};
    vecs[2] = '{32'h8000_0007, 1'b0, 32'd0,  1'b1, 32'h02};
    vecs[3] = '{32'h8000_0008, 1'b1, 32'h41, 1'b0, 32'h00};
    vecs[4] = '{32'h7FFF_FFFC, 1'b1, 32'h42, 1'b0, 32'h00};
    vecs[5] = '{32'h0000_0004, 1'b0, 32'd0,  1'b0, 32'h00};
    vecs[6] = '{32'h8000_0004, 1'b1, 32'h0,  1'b1, 32'h02};
    vecs[7] = '{32'h8000_0005, 1'b0, 32'd0,  1'b1, 32'h02};

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    read_status(st);
    check("rst_status", st, 32'h02);

    // Decode table; misses with we=1 must never push.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      address = vecs[i].addr; wdata = vecs[i].wd; we = vecs[i].wen;
      #1;
      check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      @(posedge clk);
      #1 we = 1'b0;
    end
    repeat (50) @(posedge clk);
    read_status(st);
    check("miss_no_push", st, 32'h02);

    // Single frame of 0x55, exact per-cycle waveform and busy flag.
    byte55 = 8'h55;
    tx_byte(byte55);
    address = A_ST;
    bad_idx = -1;
    busy_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i < CPB)            exp_bit = 1'b0;
      else if (i >= 9 * CPB)  exp_bit = 1'b1;
      else                    exp_bit = byte55[(i / CPB) - 1];
      if (tx !== exp_bit && bad_idx < 0) bad_idx = i;
      if (rdata[2] !== 1'b1) busy_bad++;
    end
    check("t2_tx_wave_first_bad", bad_idx, -1);
    check("t2_busy_cycles_low", busy_bad, 0);
    @(posedge clk);
    #1 check("t2_status_after", rdata, 32'h02);
    repeat (4) @(posedge clk);

    // Back-to-back bursts fill the FIFO; overflow while full mid-frame.
    start_q.delete();
    tx_byte(8'h01);
    tx_byte(8'h02);
    tx_byte(8'h03);
    tx_byte(8'h04);
    tx_byte(8'h05);
    read_status(st);
    check("t3_full_status", st, 32'h45);
    bus_write(A_TX, 32'h0000_00AA);
    read_status(st);
    check("t4_ovf_status", st, 32'h4D);
    bus_write(A_ST, 32'h0000_0008);
    read_status(st);
    check("t4_ovf_cleared", st, 32'h45);
    waited = 0;
    while (exp_q.size() != 0 && waited < 600) begin
      @(posedge clk);
      waited++;
    end
    check("t3_drain_left", exp_q.size(), 0);
    check("t3_frames_seen", start_q.size(), 5);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("t3_gap%0d", i), start_q[i] - start_q[i-1], FRAME);
    repeat (8) @(posedge clk);
    read_status(st);
    check("t3_status_idle", st, 32'h02);

    // Reset in the middle of DATA aborts the frame and flushes the FIFO.
    tx_byte(8'h3C);
    tx_byte(8'h77);
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rst_epoch++;
    @(posedge clk);
    #1;
    check("t5_tx_after_rst", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    read_status(st);
    check("t5_status", st, 32'h02);
    bad_idx = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 if (tx !== 1'b1) bad_idx++;
    end
    check("t5_tx_low_cycles", bad_idx, 0);

    repeat (20) @(posedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
